// File: rtl/core_dispatcher.sv
// ============================================================================
// Module      : core_dispatcher
// Description : Multi-core launch/completion controller. Releases a selected
//               set of cores into RUN, collects their end_process flags,
//               acknowledges each finished core and pulses done when the run
//               completes. Optional watchdog enabled by the macro
//               CORE_DISPATCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_CORES-1:0]   core_mask,
  input  logic [TIMEOUT_W-1:0]   timeout_cycles,
  input  logic [NUM_CORES-1:0]   end_process,
  output logic [2*NUM_CORES-1:0] status,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_CORES-1:0]   done_mask,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] C_LANE_HOLD = 2'b00;
  localparam logic [1:0] C_LANE_RUN  = 2'b01;
  localparam logic [1:0] C_LANE_ACK  = 2'b10;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [NUM_CORES-1:0]     r_active;
  logic [NUM_CORES-1:0]     w_active_nxt;
  logic [NUM_CORES-1:0]     r_done_mask;
  logic [NUM_CORES-1:0]     w_done_mask_nxt;
  logic [2*NUM_CORES-1:0]   r_status;
  logic [2*NUM_CORES-1:0]   w_status_nxt;
  logic                     r_busy;
  logic                     w_busy_nxt;
  logic                     r_done;
  logic                     w_done_nxt;

  logic [NUM_CORES-1:0]     w_dm_upd;
  logic                     w_complete;
  logic                     w_launch;
  logic                     w_expire;

  // Per-lane code: inactive lanes hold, active lanes run until done, then ack.
  function automatic logic [2*NUM_CORES-1:0] lane_codes(
    input logic [NUM_CORES-1:0] act,
    input logic [NUM_CORES-1:0] fin
  );
    logic [2*NUM_CORES-1:0] codes;
    codes = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (act[i]) begin
        codes[2*i +: 2] = fin[i] ? C_LANE_ACK : C_LANE_RUN;
      end else begin
        codes[2*i +: 2] = C_LANE_HOLD;
      end
    end
    return codes;
  endfunction

  // Completion view including this edge's end_process; inactive cores masked.
  assign w_dm_upd   = r_done_mask | (end_process & r_active);
  assign w_complete = (w_dm_upd == r_active);
  assign w_launch   = (r_state == S_IDLE) && start;

`ifdef CORE_DISPATCH_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] w_cnt_inc;
  logic                 r_timeout_err;

  assign w_cnt_inc = r_cnt + TIMEOUT_W'(1);
  // Completion on the expiring edge wins, so expiry requires !w_complete.
  assign w_expire  = (r_state == S_RUN) && (timeout_cycles != '0) &&
                     (w_cnt_inc == timeout_cycles) && !w_complete;

  // Watchdog counter and sticky timeout flag, cleared on each launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_launch) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else if (r_state == S_RUN && !w_complete) begin
      if (w_expire) begin
        r_timeout_err <= 1'b1;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^timeout_cycles;
  assign w_expire         = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  // Next-state and next-output computation; all outputs are registered.
  always_comb begin
    w_state_nxt     = r_state;
    w_active_nxt    = r_active;
    w_done_mask_nxt = r_done_mask;
    w_status_nxt    = '0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_done_mask_nxt = '0;
          w_busy_nxt      = 1'b1;
          if (core_mask != '0) begin
            w_active_nxt = core_mask;
            w_status_nxt = lane_codes(core_mask, '0);
            w_state_nxt  = S_RUN;
          end else begin
            w_active_nxt = '0;
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_RUN: begin
        w_done_mask_nxt = w_dm_upd;
        w_busy_nxt      = 1'b1;
        if (w_complete || w_expire) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_status_nxt = lane_codes(r_active, w_dm_upd);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any run immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_active    <= '0;
      r_done_mask <= '0;
      r_status    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_active    <= w_active_nxt;
      r_done_mask <= w_done_mask_nxt;
      r_status    <= w_status_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign status    = r_status;
  assign busy      = r_busy;
  assign done      = r_done;
  assign done_mask = r_done_mask;

endmodule

`default_nettype wire

// File: tb/tb_core_dispatcher.sv
// ============================================================================
// Module      : tb_core_dispatcher
// Description : Directed self-checking bench for core_dispatcher (4 cores).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  core_mask;
  logic [15:0] timeout_cycles;
  logic [3:0]  end_process;
  logic [7:0]  status;
  logic        busy;
  logic        done;
  logic [3:0]  done_mask;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  core_dispatcher #(.NUM_CORES(4), .TIMEOUT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .core_mask      (core_mask),
    .timeout_cycles (timeout_cycles),
    .end_process    (end_process),
    .status         (status),
    .busy           (busy),
    .done           (done),
    .done_mask      (done_mask),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] st, input logic b,
                         input logic d, input logic [3:0] dm, input logic te);
    chk({tag, ".status"}, 32'(status), 32'(st));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".done_mask"}, 32'(done_mask), 32'(dm));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(te));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; core_mask = '0; timeout_cycles = '0; end_process = '0;
    tick(); tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("idle", 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
    end

    // Staggered completion of cores 0,1,3
    core_mask = 4'b1011; timeout_cycles = 16'd0; start = 1'b1;
    tick(); start = 1'b0; core_mask = '0;
    chk_all("run_launch", 8'h45, 1'b1, 1'b0, 4'h0, 1'b0);
    tick();
    chk("run_hold", 32'(status), 32'h45);
    end_process = 4'b0001;
    tick(); end_process = '0;
    chk("core0_ack", 32'(status), 32'h46);
    // start during RUN and inactive core 2 ending: both ignored
    start = 1'b1; core_mask = 4'b0100; end_process = 4'b0100;
    tick(); start = 1'b0; core_mask = '0; end_process = '0;
    chk_all("ignored", 8'h46, 1'b1, 1'b0, 4'b0001, 1'b0);
    end_process = 4'b0010;
    tick(); end_process = '0;
    chk("core1_ack", 32'(status), 32'h4A);
    tick();
    chk("wait_core3", 32'(done), 32'h0);
    end_process = 4'b1000;
    tick(); end_process = '0;
    chk_all("run_done", 8'h00, 1'b1, 1'b1, 4'b1011, 1'b0);
    tick();
    chk_all("after_done", 8'h00, 1'b0, 1'b0, 4'b1011, 1'b0);

    // Core 2 never ends with a 20-cycle watchdog
    core_mask = 4'b1111; timeout_cycles = 16'd20; start = 1'b1;
    tick(); start = 1'b0; core_mask = '0;
    chk("wd_launch", 32'(status), 32'h55);
    end_process = 4'b1011;
    tick(); end_process = '0;
    chk("wd_partial", 32'(status), 32'h9A);
`ifdef CORE_DISPATCH_TIMEOUT_EN
    for (int i = 0; i < 18; i++) tick();
    chk_all("wd_cycle20", 8'h9A, 1'b1, 1'b0, 4'b1011, 1'b0);
    tick();
    chk_all("wd_expire", 8'h00, 1'b1, 1'b1, 4'b1011, 1'b1);
    tick();
    chk_all("wd_idle", 8'h00, 1'b0, 1'b0, 4'b1011, 1'b1);
`else
    for (int i = 0; i < 110; i++) tick();
    chk_all("nowd_persist", 8'h9A, 1'b1, 1'b0, 4'b1011, 1'b0);
    end_process = 4'b0100;
    tick(); end_process = '0;
    chk_all("nowd_done", 8'h00, 1'b1, 1'b1, 4'b1111, 1'b0);
    tick();
`endif

    // Empty mask: straight to DONE, flags cleared
    core_mask = 4'b0000; start = 1'b1;
    tick(); start = 1'b0;
    chk_all("empty_done", 8'h00, 1'b1, 1'b1, 4'h0, 1'b0);
    tick();
    chk_all("empty_idle", 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);

    // Last completion on the watchdog's expiring edge: completion wins
    core_mask = 4'b1111; timeout_cycles = 16'd5; start = 1'b1;
    tick(); start = 1'b0; core_mask = '0;
    end_process = 4'b0111;
    tick(); end_process = '0;
    chk("race_partial", 32'(status), 32'h6A);
    tick(); tick(); tick();
    chk("race_pre", 32'(done), 32'h0);
    end_process = 4'b1000;
    tick(); end_process = '0;
    chk_all("race_done", 8'h00, 1'b1, 1'b1, 4'b1111, 1'b0);
    tick();
    timeout_cycles = 16'd0;

    // Reset mid-run, then a fresh launch
    core_mask = 4'b0101; start = 1'b1;
    tick(); start = 1'b0; core_mask = '0;
    chk("rst_launch", 32'(status), 32'h11);
    tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk_all("rst_abort", 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    chk_all("rst_idle", 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
    core_mask = 4'b0010; start = 1'b1;
    tick(); start = 1'b0; core_mask = '0;
    chk_all("fresh_launch", 8'h04, 1'b1, 1'b0, 4'h0, 1'b0);
    end_process = 4'b0010;
    tick(); end_process = '0;
    chk_all("fresh_done", 8'h00, 1'b1, 1'b1, 4'b0010, 1'b0);
    tick();
    chk_all("fresh_idle", 8'h00, 1'b0, 1'b0, 4'b0010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
